// File: rtl/dth11_reader.sv
// dth11_reader: single-wire DHT11 master.
// On i_Start it drives the host start pulse, times the sensor response,
// decodes the 40-bit frame (MSB first) and reports o_Data/o_Done/o_Error.
// Optional feature: define DTH_CHECKSUM_EN to require
// byte0+byte1+byte2+byte3 (mod 256) == byte4 before a frame is accepted.
module dth11_reader #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int START_LOW_US = 20000,
  parameter int TIMEOUT_US   = 200,
  parameter int BIT1_THR_US  = 50
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  inout  wire         io_Dth,
  output logic [39:0] o_Data,
  output logic        o_Done,
  output logic        o_Error,
  output logic        o_Busy
);

  localparam int DIV_RAW = CLK_FREQ_HZ / 1_000_000;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(DIV - 1);
  localparam logic [14:0]      US_MAX      = '1;
  localparam logic [14:0]      START_CNT   = 15'(START_LOW_US - 1);
  localparam logic [14:0]      TIMEOUT_CNT = 15'(TIMEOUT_US);
  localparam logic [14:0]      BIT1_CNT    = 15'(BIT1_THR_US);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_FAIL
  } state_t;

  state_t           state;
  logic             drive_low;
  logic             dth_p0, dth_p1, dth_p2;
  logic             dth_rise, dth_fall;
  logic [PRE_W-1:0] presc_q;
  logic             us_tick;
  logic [14:0]      us_cnt;
  logic             timed_out;
  logic [5:0]       bit_cnt;
  logic [39:0]      shift_q;
  logic             frame_ok;

`ifdef DTH_CHECKSUM_EN
  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (sum == f[7:0]);
  endfunction

  assign frame_ok = checksum_ok(shift_q);
`else
  assign frame_ok = 1'b1;
`endif

  // Open drain: only ever pull low, otherwise leave the pad to the pull-up.
  assign io_Dth = drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dth_p0 <= 1'b1;
      dth_p1 <= 1'b1;
      dth_p2 <= 1'b1;
    end else begin
      dth_p0 <= io_Dth;
      dth_p1 <= dth_p0;
      dth_p2 <= dth_p1;
    end
  end

  assign dth_rise  = dth_p1 & ~dth_p2;
  assign dth_fall  = ~dth_p1 & dth_p2;
  assign us_tick   = (presc_q == PRE_LAST);
  assign timed_out = (us_cnt >= TIMEOUT_CNT);

  // Transaction FSM; also owns the us timer, which restarts on every state change.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      drive_low <= 1'b0;
      presc_q   <= '0;
      us_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      o_Data    <= '0;
      o_Done    <= 1'b0;
      o_Error   <= 1'b0;
      o_Busy    <= 1'b0;
    end else begin
      o_Done <= 1'b0;

      if (us_tick) presc_q <= '0;
      else         presc_q <= presc_q + PRE_W'(1);

      if (us_tick && (us_cnt != US_MAX)) us_cnt <= us_cnt + 15'd1;

      case (state)
        S_IDLE: begin
          if (i_Start) begin
            state     <= S_START_LOW;
            drive_low <= 1'b1;
            o_Error   <= 1'b0;
            o_Busy    <= 1'b1;
            presc_q   <= '0;
            us_cnt    <= '0;
          end
        end

        S_START_LOW: begin
          // Leave on the tick that completes the last microsecond of the pulse.
          if (us_tick && (us_cnt >= START_CNT)) begin
            state     <= S_RELEASE;
            drive_low <= 1'b0;
            presc_q   <= '0;
            us_cnt    <= '0;
          end
        end

        S_RELEASE: begin
          if (timed_out) begin
            state   <= S_FAIL;
            presc_q <= '0;
            us_cnt  <= '0;
          end else if (dth_fall) begin
            state   <= S_RESP_LOW;
            presc_q <= '0;
            us_cnt  <= '0;
          end
        end

        S_RESP_LOW: begin
          if (timed_out) begin
            state   <= S_FAIL;
            presc_q <= '0;
            us_cnt  <= '0;
          end else if (dth_rise) begin
            state   <= S_RESP_HIGH;
            presc_q <= '0;
            us_cnt  <= '0;
          end
        end

        S_RESP_HIGH: begin
          if (timed_out) begin
            state   <= S_FAIL;
            presc_q <= '0;
            us_cnt  <= '0;
          end else if (dth_fall) begin
            state   <= S_BIT_LOW;
            bit_cnt <= '0;
            presc_q <= '0;
            us_cnt  <= '0;
          end
        end

        S_BIT_LOW: begin
          if (timed_out) begin
            state   <= S_FAIL;
            presc_q <= '0;
            us_cnt  <= '0;
          end else if (dth_rise) begin
            state   <= S_BIT_HIGH;
            presc_q <= '0;
            us_cnt  <= '0;
          end
        end

        S_BIT_HIGH: begin
          if (timed_out) begin
            state   <= S_FAIL;
            presc_q <= '0;
            us_cnt  <= '0;
          end else if (dth_fall) begin
            // The edge cycle itself belongs to the last high us, so the count
            // reads one short of the pulse length: >= here means length > threshold.
            shift_q <= {shift_q[38:0], (us_cnt >= BIT1_CNT)};
            bit_cnt <= bit_cnt + 6'd1;
            state   <= (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
            presc_q <= '0;
            us_cnt  <= '0;
          end
        end

        S_CHECK: begin
          presc_q <= '0;
          us_cnt  <= '0;
          if (frame_ok) begin
            o_Data <= shift_q;
            o_Done <= 1'b1;
            o_Busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            state  <= S_FAIL;
          end
        end

        S_FAIL: begin
          o_Error <= 1'b1;
          o_Done  <= 1'b1;
          o_Busy  <= 1'b0;
          state   <= S_IDLE;
          presc_q <= '0;
          us_cnt  <= '0;
        end

        default: begin
          state     <= S_IDLE;
          drive_low <= 1'b0;
          o_Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dth11_reader.sv
// Bench for dth11_reader with a 1 MHz clock (1 cycle = 1 us), an open-drain
// sensor model on a pulled-up line, a table of fixed frames and random frames
// checked against a reference built from the pulse lengths actually sent.
`timescale 1ns/1ps
module tb_dth11_reader;

  localparam int CLK_FREQ_HZ  = 1_000_000;
  localparam int START_LOW_US = 100;
  localparam int TIMEOUT_US   = 200;
  localparam int BIT1_THR_US  = 50;

  typedef struct {
    logic [39:0] frame;
    logic        exp_err;
    logic [39:0] exp_data;
  } vec_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        bfm_low = 1'b0;
  wire         dth_line;
  logic [39:0] o_data;
  logic        o_done, o_error, o_busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  int          hi_len [40];
  int          lo_len [40];
  int          bfm_bit  = -1;
  bit          bfm_high = 1'b0;
  logic [39:0] last_good = '0;
  vec_t        vecs [4];

  pullup (dth_line);
  assign dth_line = bfm_low ? 1'b0 : 1'bz;

  dth11_reader #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .START_LOW_US(START_LOW_US),
    .TIMEOUT_US  (TIMEOUT_US),
    .BIT1_THR_US (BIT1_THR_US)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .i_Start(start),
    .io_Dth (dth_line),
    .o_Data (o_data),
    .o_Done (o_done),
    .o_Error(o_error),
    .o_Busy (o_busy)
  );

  always #500 clk = ~clk;

  // Count every o_Done pulse and remember o_Error as seen alongside it.
  always @(negedge clk) begin
    if (o_done) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= o_error;
    end
  end

  initial begin
    #(200_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Pulse lengths for a frame: fixed 26/70 us highs, or random within each class.
  task automatic set_lengths(input logic [39:0] f, input bit rnd);
    for (int i = 0; i < 40; i++) begin
      if (rnd) begin
        lo_len[i] = int'($urandom_range(55, 40));
        hi_len[i] = f[39-i] ? int'($urandom_range(80, 51)) : int'($urandom_range(50, 20));
      end else begin
        lo_len[i] = 50;
        hi_len[i] = f[39-i] ? 70 : 26;
      end
    end
  endtask

  // Reference: bit i (sent first = MSB) is 1 exactly when its high lasted > threshold.
  function automatic logic [39:0] model_bits();
    logic [39:0] f;
    f = '0;
    for (int i = 0; i < 40; i++) f[39-i] = (hi_len[i] > BIT1_THR_US);
    return f;
  endfunction

  function automatic bit model_pass(input logic [39:0] f);
    int s;
    bit chk_en;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
`ifdef DTH_CHECKSUM_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    return !chk_en || ((s % 256) == int'(f[7:0]));
  endfunction

  // Sensor model: wait for and measure the host pulse, then optionally reply.
  task automatic sensor_reply(input bit respond, output int low_seen);
    int n;
    n = 0;
    low_seen = 0;
    while (dth_line !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    while (dth_line === 1'b0 && low_seen < 1000) begin @(negedge clk); low_seen++; end
    if (respond && n < 50) begin
      repeat (30) @(negedge clk);
      bfm_low = 1'b1; repeat (80) @(negedge clk);
      bfm_low = 1'b0; repeat (80) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
        bfm_bit  = i;
        bfm_high = 1'b0;
        bfm_low  = 1'b1; repeat (lo_len[i]) @(negedge clk);
        bfm_high = 1'b1;
        bfm_low  = 1'b0; repeat (hi_len[i]) @(negedge clk);
      end
      bfm_high = 1'b0;
      bfm_low  = 1'b1; repeat (50) @(negedge clk);
      bfm_low  = 1'b0;
      bfm_bit  = -1;
    end
  endtask

  // One full read: request, sensor activity, then outcome checks.
  task automatic do_txn(input string tag, input bit respond, input int mid_start,
                        input logic exp_err, input logic [39:0] exp_data);
    int d0, low_seen, cyc;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " busy_during"}, 40'(o_busy), 40'd1);
    fork
      sensor_reply(respond, low_seen);
      begin
        if (mid_start > 0) begin
          repeat (mid_start) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    cyc = 0;
    while (done_cnt == d0 && cyc < 700) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    check_range({tag, " start_low_us"}, low_seen, START_LOW_US - 1, START_LOW_US + 1);
    check_range({tag, " done_pulses"}, done_cnt - d0, 1, 1);
    check({tag, " error_with_done"}, 40'(err_at_done), 40'(exp_err));
    check({tag, " error"}, 40'(o_error), 40'(exp_err));
    check({tag, " data"}, o_data, exp_data);
    check({tag, " busy_after"}, 40'(o_busy), 40'd0);
    if (!respond) check_range({tag, " release_to_done_us"}, cyc, TIMEOUT_US - 5, TIMEOUT_US + 10);
  endtask

  int d0_main, low_main, cyc_main;

  initial begin
    vecs[0] = '{40'h37001A0051, 1'b0, 40'h37001A0051};
`ifdef DTH_CHECKSUM_EN
    vecs[1] = '{40'h37001A0052, 1'b1, 40'h37001A0051};
`else
    vecs[1] = '{40'h37001A0052, 1'b0, 40'h37001A0052};
`endif
    vecs[2] = '{40'hFFFFFFFFFC, 1'b0, 40'hFFFFFFFFFC};
    vecs[3] = '{40'h0000000000, 1'b0, 40'h0000000000};

    // T1: reset held with a pending request.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (5) @(negedge clk);
    check("reset line_released", 40'(dth_line), 40'd1);
    check("reset data", o_data, 40'd0);
    check("reset done", 40'(o_done), 40'd0);
    check("reset error", 40'(o_error), 40'd0);
    check("reset busy", 40'(o_busy), 40'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    last_good = '0;

    // T2/T3 and extra fixed frames.
    for (int v = 0; v < 4; v++) begin
      set_lengths(vecs[v].frame, 1'b0);
      do_txn($sformatf("vec%0d", v), 1'b1, 0, vecs[v].exp_err, vecs[v].exp_data);
      last_good = vecs[v].exp_data;
    end

    // T4: sensor silent.
    do_txn("no_response", 1'b0, 0, 1'b1, last_good);

    // T5: threshold lengths 26/50/51/70 us on the first four bits.
    set_lengths(40'h3000100040, 1'b0);
    hi_len[0] = 26; hi_len[1] = 50; hi_len[2] = 51; hi_len[3] = 70;
    do_txn("bit_threshold", 1'b1, 0, 1'b0, 40'h3000100040);
    last_good = 40'h3000100040;

    // Random frames, checksum correct or off by one.
    for (int k = 0; k < 5; k++) begin
      logic [39:0] f, mf;
      logic [7:0]  s;
      bit          pass;
      f[39:8] = $urandom;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      f[7:0] = s ^ (($urandom_range(1, 0) == 1) ? 8'h01 : 8'h00);
      set_lengths(f, 1'b1);
      mf   = model_bits();
      pass = model_pass(mf);
      do_txn($sformatf("rand%0d", k), 1'b1, 0, !pass, pass ? mf : last_good);
      if (pass) last_good = mf;
    end

    // T6a: a request pulsed in the middle of a frame is ignored.
    set_lengths(40'h37001A0051, 1'b0);
    do_txn("mid_start", 1'b1, 1000, 1'b0, 40'h37001A0051);
    last_good = 40'h37001A0051;

    // T6b: reset while the sensor holds a data-high phase.
    set_lengths(40'h37001A0051, 1'b0);
    d0_main = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      sensor_reply(1'b1, low_main);
      begin
        cyc_main = 0;
        while (!(bfm_bit == 10 && bfm_high) && cyc_main < 5000) begin
          @(negedge clk);
          cyc_main++;
        end
        check_range("rst reached_bit_high", cyc_main, 0, 4999);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst line_released", 40'(dth_line), 40'd1);
        check("rst busy_in_reset", 40'(o_busy), 40'd0);
        rst_n = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check_range("rst no_done", done_cnt - d0_main, 0, 0);
    check("rst data_cleared", o_data, 40'd0);
    check("rst error_cleared", 40'(o_error), 40'd0);
    check("rst busy_after", 40'(o_busy), 40'd0);
    last_good = '0;

    // T6c: the next request reads correctly.
    set_lengths(40'h37001A0051, 1'b0);
    do_txn("after_reset", 1'b1, 0, 1'b0, 40'h37001A0051);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
